switch_debounce: RTL

- Input conditioning stage between the board slide switches and the half_adder switch inputs (stswi).
- Per switch channel: synchronises the raw asynchronous level into clk, filters contact bounce, and drives a clean level.
- Also drives one-cycle rise/fall strobes for later counter/FSM exercises.
- Outputs map directly onto the half_adder stswi[N-1:0] vector.

---
 rtl/switch_debounce_pkg.sv | 20 ++
 rtl/switch_debounce_if.sv | 28 ++
 rtl/switch_debounce_chan.sv | 138 +++++++++++++
 rtl/switch_debounce.sv | 49 ++++
 4 files changed

// File: rtl/switch_debounce_pkg.sv
// Shared definitions for the switch conditioning block.
//   CLK_HZ_DEFAULT : board system clock frequency in Hz
//   db_state_e     : per-channel debounce FSM encoding
//   stable_cycles(): converts a debounce time into a clock-cycle count
package switch_debounce_pkg;

  localparam int unsigned CLK_HZ_DEFAULT = 12_000_000;

  typedef enum logic [1:0] {
    StLow    = 2'd0,
    StWaitHi = 2'd1,
    StHigh   = 2'd2,
    StWaitLo = 2'd3
  } db_state_e;

  function automatic int unsigned stable_cycles(int unsigned clk_hz, int unsigned us);
    return clk_hz / 1_000_000 * us;
  endfunction

endpackage

// File: rtl/switch_debounce_if.sv
// Switch bundle between the board switches and the half_adder inputs.
//   swi_raw  : raw asynchronous switch levels
//   swi_db   : debounced levels (half_adder stswi)
//   swi_rise : one-cycle 0->1 strobe per channel
//   swi_fall : one-cycle 1->0 strobe per channel
// master drives the raw levels and consumes the results; slave is the debouncer.
interface switch_debounce_if #(
  parameter int unsigned N = 2
);
  logic [N-1:0] swi_raw;
  logic [N-1:0] swi_db;
  logic [N-1:0] swi_rise;
  logic [N-1:0] swi_fall;

  modport master (
    output swi_raw,
    input  swi_db,
    input  swi_rise,
    input  swi_fall
  );

  modport slave (
    input  swi_raw,
    output swi_db,
    output swi_rise,
    output swi_fall
  );
endinterface

// File: rtl/switch_debounce_chan.sv
// One switch channel: two-flop synchroniser, stable-sample counter and
// LOW / WAIT_HI / HIGH / WAIT_LO filter FSM with registered outputs.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low clear
//   raw   : raw switch level, asynchronous to clk
//   db    : debounced level
//   rise  : one-cycle pulse when db goes 0->1
//   fall  : one-cycle pulse when db goes 1->0
module switch_debounce_chan
  import switch_debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic db,
  output logic rise,
  output logic fall
);

  localparam int unsigned CntW = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  logic            s1_q, s2_q;
  db_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            db_q, db_d;
  logic            rise_q, rise_d;
  logic            fall_q, fall_d;

  // Synchroniser: only s2_q is used past this point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StLow;
      cnt_q   <= '0;
      db_q    <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Next state and counter. The counter is cleared on every exit from a
  // WAIT_* state, so it never needs to count past CntLast.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StLow: begin
        if (s2_q) begin
          state_d = StWaitHi;
          cnt_d   = CntOne;
        end else begin
          cnt_d = '0;
        end
      end
      StWaitHi: begin
        if (!s2_q) begin
          state_d = StLow;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = StHigh;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StHigh: begin
        if (!s2_q) begin
          state_d = StWaitLo;
          cnt_d   = CntOne;
        end else begin
          cnt_d = '0;
        end
      end
      StWaitLo: begin
        if (s2_q) begin
          state_d = StHigh;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = StLow;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        state_d = StLow;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: the level only moves on a qualified transition, strobes last one cycle.
  always_comb begin
    db_d   = db_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    unique case (state_q)
      StWaitHi: begin
        if (s2_q && (cnt_q == CntLast)) begin
          db_d   = 1'b1;
          rise_d = 1'b1;
        end
      end
      StWaitLo: begin
        if (!s2_q && (cnt_q == CntLast)) begin
          db_d   = 1'b0;
          fall_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign db   = db_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/switch_debounce.sv
// Debounces N board slide switches for the half_adder stswi inputs.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low clear
//   sw    : switch bundle (slave): swi_raw in; swi_db, swi_rise, swi_fall out
// A held level change reaches swi_db STABLE_CYCLES+1 edges after it is first
// sampled (2 synchroniser edges plus the filter).
module switch_debounce
  import switch_debounce_pkg::*;
#(
  parameter int unsigned N             = 2,
  parameter int unsigned CLK_HZ        = CLK_HZ_DEFAULT,
  parameter int unsigned DEBOUNCE_US   = 10_000,
  parameter int unsigned STABLE_CYCLES = stable_cycles(CLK_HZ, DEBOUNCE_US)
) (
  input logic              clk,
  input logic              rst_n,
  switch_debounce_if.slave sw
);

`ifndef SYNTHESIS
  initial begin
    if (STABLE_CYCLES < 2) begin
      $error("switch_debounce: STABLE_CYCLES must be >= 2, got %0d", STABLE_CYCLES);
    end
  end
`endif

  logic [N-1:0] db_w;
  logic [N-1:0] rise_w;
  logic [N-1:0] fall_w;

  for (genvar i = 0; i < N; i++) begin : g_chan
    switch_debounce_chan #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_chan (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (sw.swi_raw[i]),
      .db   (db_w[i]),
      .rise (rise_w[i]),
      .fall (fall_w[i])
    );
  end

  assign sw.swi_db   = db_w;
  assign sw.swi_rise = rise_w;
  assign sw.swi_fall = fall_w;

endmodule
